// File: rtl/adder_meas_pkg.sv
// Shared types and default sizing for the adder measurement sequencer.
package adder_meas_pkg;

  localparam int unsigned DefCountW = 24;
  localparam int unsigned DefWinW   = 16;
  localparam int unsigned DefSettle = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StReport
  } state_e;

endpackage

// File: rtl/adder_meas_counter.sv
// Saturating ring-tick counter plus a shared down-counting phase timer
// (used for both the operand settle time and the gate window).
module adder_meas_counter #(
  parameter int unsigned COUNT_W = 24,
  parameter int unsigned WIN_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cnt_clr_i,
  input  logic               cnt_en_i,
  input  logic               tmr_load_i,
  input  logic [WIN_W-1:0]   tmr_val_i,
  input  logic               tmr_dec_i,
  output logic [COUNT_W-1:0] cnt_o,
  output logic               tmr_expired_o
);

  logic [COUNT_W-1:0] cnt_q;
  logic [WIN_W-1:0]   tmr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_q <= '0;
    end else if (tmr_load_i) begin
      tmr_q <= tmr_val_i;
    end else if (tmr_dec_i && (tmr_q != '0)) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  // The loaded value is the number of cycles to spend; the last one is at 1.
  assign tmr_expired_o = (tmr_q < WIN_W'(2));
  assign cnt_o         = cnt_q;

endmodule

// File: rtl/adder_measure_sequencer.sv
// Sweeps sum taps of the instrumented adder, gating the ring oscillator for a
// programmed window per tap and reporting the synchronized tick count.
module adder_measure_sequencer
  import adder_meas_pkg::*;
#(
  parameter int unsigned COUNT_W = DefCountW,
  parameter int unsigned WIN_W   = DefWinW,
  parameter int unsigned SETTLE  = DefSettle
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        cfg_a,
  input  logic [31:0]        cfg_b,
  input  logic [4:0]         cfg_bit_first,
  input  logic [4:0]         cfg_bit_last,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               ring_tick,
  input  logic               res_ready,
  output logic [31:0]        adder_a,
  output logic [31:0]        adder_b,
  output logic [31:0]        tap_sel,
  output logic               ring_en,
  output logic               res_valid,
  output logic [4:0]         res_bit,
  output logic [COUNT_W-1:0] res_count,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [4:0]         bit_q, bit_d, last_q;
  logic [WIN_W-1:0]   win_q;
  logic [31:0]        a_q, b_q, tap_q;
  logic               ring_en_q, res_valid_q, done_q, done_d;
  logic [4:0]         res_bit_q;
  logic [COUNT_W-1:0] cnt;
  logic               tmr_expired;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          bit_d   = cfg_bit_first;
        end
      end
      StLoad:   if (tmr_expired) state_d = StRun;
      StRun:    if (tmr_expired) state_d = StReport;
      StReport: begin
        if (res_ready) begin
          if (bit_q < last_q) begin
            state_d = StLoad;
            bit_d   = bit_q + 5'd1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      bit_q       <= '0;
      last_q      <= '0;
      win_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tap_q       <= '0;
      ring_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      if ((state_q == StIdle) && (state_d == StLoad)) begin
        a_q    <= cfg_a;
        b_q    <= cfg_b;
        last_q <= (cfg_bit_first > cfg_bit_last) ? cfg_bit_first : cfg_bit_last;
        win_q  <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;
      end else if (state_d == StIdle) begin
        a_q <= '0;
        b_q <= '0;
      end
      tap_q       <= (state_d == StIdle) ? '0 : (32'd1 << bit_d);
      ring_en_q   <= (state_d == StRun);
      res_valid_q <= (state_d == StReport);
      res_bit_q   <= (state_d == StReport) ? bit_d : '0;
      done_q      <= done_d;
    end
  end

  adder_meas_counter #(
    .COUNT_W(COUNT_W),
    .WIN_W  (WIN_W)
  ) u_counter (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .cnt_clr_i    ((state_d == StLoad) && (state_q != StLoad)),
    .cnt_en_i     ((state_q == StRun) && ring_tick),
    .tmr_load_i   (state_d != state_q),
    .tmr_val_i    ((state_d == StLoad) ? WIN_W'(SETTLE) : win_q),
    .tmr_dec_i    ((state_q == StLoad) || (state_q == StRun)),
    .cnt_o        (cnt),
    .tmr_expired_o(tmr_expired)
  );

  assign adder_a   = a_q;
  assign adder_b   = b_q;
  assign tap_sel   = tap_q;
  assign ring_en   = ring_en_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_count = res_valid_q ? cnt : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer; a second instance with a 4-bit
// counter shares all stimulus to expose saturation.
module tb_adder_measure_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, ring_tick = 1'b0, res_ready = 1'b0;
  logic [31:0] cfg_a = '0, cfg_b = '0;
  logic [4:0]  first = '0, last = '0;
  logic [15:0] window = '0;

  logic [31:0] adder_a, adder_b, tap_sel;
  logic        ring_en, res_valid, busy, done;
  logic [4:0]  res_bit;
  logic [23:0] res_count;

  logic [31:0] a4, b4, tap4;
  logic        ring_en4, res_valid4, busy4, done4;
  logic [4:0]  res_bit4;
  logic [3:0]  res_count4;

  int vectors = 0;
  int errs    = 0;
  int ndone   = 0;

  always #5 clk = ~clk;

  adder_measure_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_bit_first(first), .cfg_bit_last(last),
    .cfg_window(window), .ring_tick(ring_tick), .res_ready(res_ready),
    .adder_a(adder_a), .adder_b(adder_b), .tap_sel(tap_sel), .ring_en(ring_en),
    .res_valid(res_valid), .res_bit(res_bit), .res_count(res_count),
    .busy(busy), .done(done)
  );

  adder_measure_sequencer #(.COUNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_bit_first(first), .cfg_bit_last(last),
    .cfg_window(window), .ring_tick(ring_tick), .res_ready(res_ready),
    .adder_a(a4), .adder_b(b4), .tap_sel(tap4), .ring_en(ring_en4),
    .res_valid(res_valid4), .res_bit(res_bit4), .res_count(res_count4),
    .busy(busy4), .done(done4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ring_en"}, ring_en, 0);
    chk({tag, "_tap"}, tap_sel, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_res_bit"}, res_bit, 0);
    chk({tag, "_adder_a"}, adder_a, 0);
    chk({tag, "_adder_b"}, adder_b, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_idle("rst_hold");
    rst = 1'b0;
    step();
    chk_idle("rst_rel");

    // Single tap, full-carry operands, tick every cycle
    cfg_a = 32'hFFFF_FFFF; cfg_b = 32'h1; first = 5'd0; last = 5'd0; window = 16'd10;
    ring_tick = 1'b1; res_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_adder_a", adder_a, 32'hFFFF_FFFF);
    chk("t1_adder_b", adder_b, 32'h1);
    chk("t1_tap", tap_sel, 32'h1);
    chk("t1_busy", busy, 1);
    for (int c = 1; c <= 16; c++) begin
      chk("t1_ring_en", ring_en, 32'((c >= 5) && (c <= 14)));
      chk("t1_res_valid", res_valid, 32'(c == 15));
      chk("t1_done", done, 32'(c == 16));
      if (c == 15) begin
        chk("t1_res_count", res_count, 10);
        chk("t1_res_bit", res_bit, 0);
        chk("t1_res_count4", res_count4, 10);
      end
      if (c == 16) chk("t1_busy_end", busy, 0);
      if (c < 16) step();
    end
    step();

    // Sweep bits 3..5, ticks on alternate cycles
    first = 5'd3; last = 5'd5; window = 16'd8; ring_tick = 1'b0; start = 1'b1;
    ndone = 0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      chk("t2_res_valid", res_valid, 32'((c == 13) || (c == 26) || (c == 39)));
      if ((c == 13) || (c == 26) || (c == 39)) begin
        chk("t2_res_bit", res_bit, 32'(3 + (c - 13) / 13));
        chk("t2_res_count", res_count, 4);
      end
      if ((c == 1) || (c == 14) || (c == 27)) chk("t2_tap", tap_sel, 32'h8 << ((c - 1) / 13));
      if (done) ndone++;
      ring_tick = ~ring_tick;
      step();
    end
    chk("t2_done_pulses", ndone, 1);

    // Saturation on the 4-bit instance
    first = 5'd0; last = 5'd0; window = 16'd40; ring_tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 45; c++) step();
    chk("t3_res_valid", res_valid, 1);
    chk("t3_res_count", res_count, 40);
    chk("t3_res_count4_sat", res_count4, 15);
    step();
    chk("t3_done", done, 1);
    step();

    // Back-pressure: res_ready low for 7 cycles in REPORT
    first = 5'd1; last = 5'd2; window = 16'd3; res_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    for (int c = 8; c <= 14; c++) begin
      chk("t4_res_valid", res_valid, 1);
      chk("t4_res_bit", res_bit, 1);
      chk("t4_res_count", res_count, 3);
      chk("t4_ring_en", ring_en, 0);
      chk("t4_tap", tap_sel, 32'h2);
      step();
    end
    chk("t4_res_valid_h", res_valid, 1);
    res_ready = 1'b1;
    step();
    chk("t4_next_load_busy", busy, 1);
    chk("t4_next_load_valid", res_valid, 0);
    chk("t4_next_load_tap", tap_sel, 32'h4);
    for (int c = 16; c < 23; c++) step();
    chk("t4_bit2_valid", res_valid, 1);
    chk("t4_bit2_bit", res_bit, 2);
    step();
    chk("t4_done", done, 1);
    step();

    // Abort mid-RUN; start while busy ignored
    cfg_a = 32'h1234_5678; cfg_b = 32'h0000_00FF; first = 5'd0; last = 5'd0;
    window = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; cfg_a = 32'hDEAD_BEEF; first = 5'd7;
    step();
    start = 1'b0;
    chk("t5_cfg_held_a", adder_a, 32'h1234_5678);
    chk("t5_cfg_held_tap", tap_sel, 32'h1);
    for (int c = 4; c < 7; c++) step();
    chk("t5_in_run", ring_en, 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk_idle("t5_abort");
    for (int c = 0; c < 12; c++) begin
      chk("t5_no_valid", res_valid, 0);
      chk("t5_no_done", done, 0);
      step();
    end

    // Reset mid-RUN
    cfg_a = 32'h1234_5678; first = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    chk("t6_in_run", ring_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t6_reset");
    for (int c = 0; c < 12; c++) begin
      chk("t6_no_valid", res_valid, 0);
      chk("t6_no_done", done, 0);
      step();
    end

    // Zero window, reversed range, restart on the done cycle
    window = 16'd0; first = 5'd9; last = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t7_tap", tap_sel, 32'h200);
    for (int c = 1; c < 5; c++) step();
    chk("t7_ring_en_on", ring_en, 1);
    step();
    chk("t7_ring_en_off", ring_en, 0);
    chk("t7_res_valid", res_valid, 1);
    chk("t7_res_bit", res_bit, 9);
    chk("t7_res_count", res_count, 1);
    step();
    chk("t7_done", done, 1);
    chk("t7_idle", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t7_restart_busy", busy, 1);
    chk("t7_restart_tap", tap_sel, 32'h200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t7_abort_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
